// File: rtl/hazard_detect.sv
// Pipeline hazard unit: load-use stall, branch flush, LSU-busy freeze with
// timeout detection and saturating stall/flush performance counters.
module hazard_detect #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_hzd_inst_decode,
   input  logic [4:0]  i_hzd_rd_addr_at_execute,
   input  logic        i_hzd_mem_rden_at_execute,
   input  logic        i_hzd_branch_taken,
   input  logic        i_hzd_lsu_busy,
   input  logic        i_hzd_err_clr,
   output logic        o_hzd_pc_en,
   output logic        o_hzd_if_id_en,
   output logic        o_hzd_id_ex_en,
   output logic        o_hzd_ex_mem_en,
   output logic        o_hzd_if_id_flush,
   output logic        o_hzd_id_ex_flush,
   output logic        o_hzd_freeze,
   output logic        o_hzd_timeout,
   output logic [15:0] o_hzd_stall_cnt,
   output logic [15:0] o_hzd_flush_cnt
);

   typedef enum logic {RUN, FREEZE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  busy_cnt, busy_cnt_nxt;
   logic        branch_held;
   logic        rs1_use, rs2_use, load_use;
   logic        branch_flush, timeout_set;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2;

   assign opcode = i_hzd_inst_decode[6:0];
   assign rs1    = i_hzd_inst_decode[19:15];
   assign rs2    = i_hzd_inst_decode[24:20];

   always_comb begin
      rs1_use = 1'b0;
      rs2_use = 1'b0;
      case (opcode)
         7'b0110011, 7'b0100011, 7'b1100011: begin
            rs1_use = 1'b1;
            rs2_use = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: rs1_use = 1'b1;
         default: ;
      endcase
   end

   assign load_use = i_hzd_mem_rden_at_execute && (i_hzd_rd_addr_at_execute != '0) &&
                     ((rs1_use && (rs1 == i_hzd_rd_addr_at_execute)) ||
                      (rs2_use && (rs2 == i_hzd_rd_addr_at_execute)));

   // A branch resolved while EX is frozen is remembered so its flush lands
   // on the first non-busy cycle even if the input has already dropped.
   assign branch_flush = !i_hzd_lsu_busy && (i_hzd_branch_taken || branch_held);

   always_comb begin
      state_nxt         = i_hzd_lsu_busy ? FREEZE : RUN;
      o_hzd_pc_en       = 1'b1;
      o_hzd_if_id_en    = 1'b1;
      o_hzd_id_ex_en    = 1'b1;
      o_hzd_ex_mem_en   = 1'b1;
      o_hzd_if_id_flush = 1'b0;
      o_hzd_id_ex_flush = 1'b0;
      if (i_hzd_lsu_busy) begin
         o_hzd_pc_en     = 1'b0;
         o_hzd_if_id_en  = 1'b0;
         o_hzd_id_ex_en  = 1'b0;
         o_hzd_ex_mem_en = 1'b0;
      end else if (branch_flush) begin
         o_hzd_if_id_flush = 1'b1;
         o_hzd_id_ex_flush = 1'b1;
      end else if (load_use) begin
         o_hzd_pc_en       = 1'b0;
         o_hzd_if_id_en    = 1'b0;
         o_hzd_id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      busy_cnt_nxt = '0;
      if (state == FREEZE && i_hzd_lsu_busy)
         busy_cnt_nxt = (busy_cnt == '1) ? busy_cnt : busy_cnt + 8'd1;
   end

   // Timeout fires on the edge where the counter reaches TIMEOUT_CYC.
   assign timeout_set = (state == FREEZE) && i_hzd_lsu_busy &&
                        (({1'b0, busy_cnt} + 9'd1) == 9'(TIMEOUT_CYC));

   assign o_hzd_freeze = (state == FREEZE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= RUN;
         busy_cnt        <= '0;
         branch_held     <= 1'b0;
         o_hzd_timeout   <= 1'b0;
         o_hzd_stall_cnt <= '0;
         o_hzd_flush_cnt <= '0;
      end else begin
         state       <= state_nxt;
         busy_cnt    <= busy_cnt_nxt;
         branch_held <= i_hzd_lsu_busy ? (branch_held || i_hzd_branch_taken) : 1'b0;
         if (timeout_set)
            o_hzd_timeout <= 1'b1;
         else if (i_hzd_err_clr)
            o_hzd_timeout <= 1'b0;
         if (!o_hzd_pc_en && o_hzd_stall_cnt != '1)
            o_hzd_stall_cnt <= o_hzd_stall_cnt + 16'd1;
         if (branch_flush && o_hzd_flush_cnt != '1)
            o_hzd_flush_cnt <= o_hzd_flush_cnt + 16'd1;
      end
   end

endmodule
